regfile_wb: RTL and testbench

//  Consumer end of the EX-stage result interface (we/waddr/wdata). Registers each EX result
//  in a one-entry write-back stage, commits it to a 32x32 general register file one cycle

---
 rtl/regfile_wb.sv | 93 +++++++++
 tb/tb_regfile_wb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Write-back stage plus 32-entry register file with two forwarding read ports.
// Ports: clk/rst, stall/flush, EX result in, two read ports, registered wb_* out.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we_o    <= 1'b0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
    end else if (flush_i) begin
      wb_we_o    <= 1'b0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
    end else if (!stall_i) begin
      wb_we_o    <= ex_we_i;
      wb_waddr_o <= ex_waddr_i;
      wb_wdata_o <= ex_wdata_i;
    end
  end

  // The held entry commits regardless of stall/flush;
  // flush only affects what the stage holds next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_we_o && wb_waddr_o != '0) begin
      regs[wb_waddr_o] <= wb_wdata_o;
    end
  end

  // Youngest producer wins: EX over WB over array.
  function automatic logic [DATA_W-1:0] rd_mux(
    input logic              re,
    input logic [ADDR_W-1:0] a,
    input logic              exw,
    input logic [ADDR_W-1:0] exa,
    input logic [DATA_W-1:0] exd,
    input logic              wbw,
    input logic [ADDR_W-1:0] wba,
    input logic [DATA_W-1:0] wbd,
    input logic [DATA_W-1:0] arr
  );
    if (!re)
      return '0;
    else if (a == '0)
      return '0;
    else if (exw && exa == a)
      return exd;
    else if (wbw && wba == a)
      return wbd;
    else
      return arr;
  endfunction

  always_comb begin
    rdata1_o = rd_mux(re1_i, raddr1_i,
                      ex_we_i, ex_waddr_i, ex_wdata_i,
                      wb_we_o, wb_waddr_o, wb_wdata_o,
                      regs[raddr1_i]);
  end

  always_comb begin
    rdata2_o = rd_mux(re2_i, raddr2_i,
                      ex_we_i, ex_waddr_i, ex_wdata_i,
                      wb_we_o, wb_waddr_o, wb_wdata_o,
                      regs[raddr2_i]);
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: driver pushes model predictions,
// monitor pops and compares on the falling edge.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ex_we_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic        re1_i = 1'b0;
  logic [4:0]  raddr1_i = '0;
  logic [31:0] rdata1_o;
  logic        re2_i = 1'b0;
  logic [4:0]  raddr2_i = '0;
  logic [31:0] rdata2_o;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  regfile_wb dut (
    .clk(clk), .rst(rst),
    .stall_i(stall_i), .flush_i(flush_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i),
    .rdata1_o(rdata1_o),
    .re2_i(re2_i), .raddr2_i(raddr2_i),
    .rdata2_o(rdata2_o),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int step_id = 0;

  // Reference state: architectural registers plus the one pending result.
  logic [31:0] m_regs [32];
  logic        m_pv;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pv = 1'b0;
    m_pa = '0;
    m_pd = '0;
  endtask

  // Effect of one rising edge, using the inputs that were present at it.
  task automatic m_edge();
    if (!rst) return;
    if (m_pv && m_pa != 0) m_regs[m_pa] = m_pd;
    if (flush_i) begin
      m_pv = 1'b0; m_pa = '0; m_pd = '0;
    end else if (!stall_i) begin
      m_pv = ex_we_i; m_pa = ex_waddr_i; m_pd = ex_wdata_i;
    end
  endtask

  function automatic logic [31:0] m_read(input logic re,
                                         input logic [4:0] a);
    if (!re || a == 0) return '0;
    if (ex_we_i && ex_waddr_i == a) return ex_wdata_i;
    if (m_pv && m_pa == a) return m_pd;
    return m_regs[a];
  endfunction

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic e1, input logic [4:0] a1,
                      input logic e2, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    m_edge();
    rst = r;
    if (!r) m_reset();
    stall_i = st; flush_i = fl;
    ex_we_i = we; ex_waddr_i = wa; ex_wdata_i = wd;
    re1_i = e1; raddr1_i = a1;
    re2_i = e2; raddr2_i = a2;
    step_id++;
    e.id = step_id;
    e.r1 = m_read(e1, a1);
    e.r2 = m_read(e2, a2);
    e.we = m_pv; e.wa = m_pa; e.wd = m_pd;
    q.push_back(e);
  endtask

  task automatic cmp(input int id, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step%0d %s got %h expected %h", id, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.id, "rdata1", rdata1_o, e.r1);
      cmp(e.id, "rdata2", rdata2_o, e.r2);
      cmp(e.id, "wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
      cmp(e.id, "wb_waddr", {27'd0, wb_waddr_o}, {27'd0, e.wa});
      cmp(e.id, "wb_wdata", wb_wdata_o, e.wd);
    end
  end

  initial begin
    m_reset();
    // reset state
    step(0, 0, 0, 0, 0, 0, 1, 5, 1, 9);
    step(1, 0, 0, 0, 0, 0, 1, 5, 1, 31);
    // ex -> wb -> array forwarding of r5
    step(1, 0, 0, 1, 5, 32'h1234_5678, 1, 5, 1, 5);
    step(1, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    step(1, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    // ex beats wb on r3
    step(1, 0, 0, 1, 3, 32'hAAAA_0000, 1, 3, 0, 3);
    step(1, 0, 0, 1, 3, 32'h0000_5555, 1, 3, 1, 3);
    step(1, 0, 0, 0, 0, 0, 1, 3, 1, 3);
    // writes to r0 never visible
    step(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // stall holds r7=0x11 while EX shows r7=0x22 with we=0
    step(1, 0, 0, 1, 7, 32'h11, 1, 7, 1, 7);
    step(1, 1, 0, 0, 7, 32'h22, 1, 7, 1, 7);
    step(1, 1, 0, 0, 7, 32'h22, 1, 7, 1, 7);
    step(1, 1, 0, 0, 7, 32'h22, 1, 7, 1, 7);
    step(1, 0, 0, 1, 8, 32'h33, 1, 7, 1, 8);
    step(1, 0, 0, 0, 0, 0, 1, 7, 1, 8);
    // flush beats stall; held r9 still commits
    step(1, 0, 0, 1, 9, 32'h99, 1, 9, 0, 9);
    step(1, 1, 1, 0, 0, 0, 1, 9, 1, 9);
    step(1, 0, 0, 0, 0, 0, 1, 9, 1, 9);
    // async reset with r4 in flight
    step(1, 0, 0, 1, 4, 32'hDEAD, 1, 4, 1, 4);
    step(0, 0, 0, 0, 0, 0, 1, 4, 1, 9);
    step(1, 0, 0, 0, 0, 0, 1, 4, 1, 9);
    step(1, 0, 0, 0, 0, 0, 1, 4, 1, 5);
    // randomized traffic on a small address window for collisions
    for (int n = 0; n < 400; n++) begin
      step(1,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) != 0),
           5'($urandom_range(0, 7)),
           $urandom(),
           ($urandom_range(0, 4) != 0),
           5'($urandom_range(0, 7)),
           ($urandom_range(0, 4) != 0),
           5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
